// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring shift-subtract step per cycle,
// fixed latency of Width+1 edges from the accepted start to the done pulse.
module mul_div_unit #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [Width-1:0] operand_a_i,
  input  logic [Width-1:0] operand_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Width-1:0] hi_o,
  output logic [Width-1:0] lo_o,
  output logic             div_by_zero_o
);

  localparam int unsigned CntW = $clog2(Width);

  typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             neg_rem_q, neg_rem_d;
  logic             b_zero_q, b_zero_d;
  logic [Width-1:0] a_q, a_d;
  logic [Width-1:0] addend_q, addend_d;
  logic [Width-1:0] acc_hi_q, acc_hi_d;
  logic [Width-1:0] acc_lo_q, acc_lo_d;
  logic [Width-1:0] hi_q, hi_d;
  logic [Width-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic             a_neg, b_neg;
  logic [Width-1:0] a_mag, b_mag;
  assign a_neg = op_i[0] & operand_a_i[Width-1];
  assign b_neg = op_i[0] & operand_b_i[Width-1];
  assign a_mag = a_neg ? -operand_a_i : operand_a_i;
  assign b_mag = b_neg ? -operand_b_i : operand_b_i;

  // Multiply: acc_lo holds the multiplier, consumed LSB-first while the product shifts in.
  // Divide: acc_lo holds the dividend, replaced MSB-first by quotient bits; acc_hi is the remainder.
  logic [Width:0]   mul_sum;
  logic [Width:0]   div_shift;
  logic [Width-1:0] div_diff;
  logic             div_ge;
  assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, addend_q} : '0);
  assign div_shift = {acc_hi_q, acc_lo_q[Width-1]};
  assign div_ge    = div_shift >= {1'b0, addend_q};
  assign div_diff  = div_shift[Width-1:0] - addend_q;

  logic [2*Width-1:0] prod_raw, prod_fix;
  logic [Width-1:0]   quo_fix, rem_fix;
  assign prod_raw = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_q ? -prod_raw : prod_raw;
  assign quo_fix  = neg_q ? -acc_lo_q : acc_lo_q;
  assign rem_fix  = neg_rem_q ? -acc_hi_q : acc_hi_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      b_zero_q  <= 1'b0;
      a_q       <= '0;
      addend_q  <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      b_zero_q  <= b_zero_d;
      a_q       <= a_d;
      addend_q  <= addend_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StCalc;
      StCalc:  if (cnt_q == CntW'(Width - 1)) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    b_zero_d  = b_zero_q;
    a_d       = a_q;
    addend_d  = addend_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          is_div_d  = op_i[1];
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          b_zero_d  = (operand_b_i == '0);
          a_d       = operand_a_i;
          addend_d  = op_i[1] ? b_mag : a_mag;
          acc_hi_d  = '0;
          acc_lo_d  = op_i[1] ? a_mag : b_mag;
          cnt_d     = '0;
          busy_d    = 1'b1;
        end
      end
      StCalc: begin
        cnt_d = cnt_q + CntW'(1);
        if (is_div_q) begin
          acc_hi_d = div_ge ? div_diff : div_shift[Width-1:0];
          acc_lo_d = {acc_lo_q[Width-2:0], div_ge};
        end else begin
          acc_hi_d = mul_sum[Width:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[Width-1:1]};
        end
      end
      StFin: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        if (is_div_q && b_zero_q) begin
          hi_d  = a_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: arithmetic reference model with fixed-latency timing, per-cycle
// output compare, and directed vectors with hand-computed results.
module tb_mul_div_unit;

  localparam int WIDTH = 32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opa, opb;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  mul_div_unit #(.Width(WIDTH)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .op_i         (op),
    .operand_a_i  (opa),
    .operand_b_i  (opb),
    .busy_o       (busy),
    .done_o       (done),
    .hi_o         (hi),
    .lo_o         (lo),
    .div_by_zero_o(dbz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Result as {div_by_zero, hi, lo} straight from the arithmetic definitions.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    logic        [63:0] up;
    logic signed [63:0] sp;
    logic signed [31:0] sa, sb, q, r;
    case (o)
      2'b00: begin
        up = {32'b0, a} * {32'b0, b};
        return {1'b0, up};
      end
      2'b01: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return {1'b0, sp};
      end
      2'b10: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h0, 32'h8000_0000};
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
        return {1'b0, r, q};
      end
    endcase
  endfunction

  // Expected outputs: done exactly WIDTH+1 edges after an accepted start.
  logic        m_busy, m_done, m_dbz;
  logic [31:0] m_hi, m_lo;
  logic [64:0] m_res;
  int          m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_left <= 0;
      m_res  <= '0;
    end else begin
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_busy <= 1'b1;
          m_left <= WIDTH + 1;
          m_res  <= model(op, opa, opb);
        end
      end else if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_dbz  <= m_res[64];
        m_hi   <= m_res[63:32];
        m_lo   <= m_res[31:0];
      end else begin
        m_left <= m_left - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    opa   = a;
    opb   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 2'($urandom);
    opa   = $urandom;
    opb   = $urandom;
  endtask

  task automatic wait_done(input string name, input int already, input logic [31:0] eh,
                           input logic [31:0] el, input logic ed);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 40);
    chk({name, " latency"}, 64'(n + already), 64'(WIDTH + 1));
    chk({name, " hi"}, {32'b0, hi}, {32'b0, eh});
    chk({name, " lo"}, {32'b0, lo}, {32'b0, el});
    chk({name, " div_by_zero"}, {63'b0, dbz}, {63'b0, ed});
    chk({name, " model_hi"}, {32'b0, m_hi}, {32'b0, eh});
    chk({name, " model_lo"}, {32'b0, m_lo}, {32'b0, el});
  endtask

  task automatic run(input string name, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                     input logic ed);
    issue(o, a, b);
    wait_done(name, 0, eh, el, ed);
    if (ed) begin
      @(posedge clk);
      #1;
      chk({name, " dbz_one_cycle"}, {63'b0, dbz}, 64'd0);
      chk({name, " done_one_cycle"}, {63'b0, done}, 64'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    opa   = '0;
    opb   = '0;
    fork
      forever begin
        @(negedge clk);
        chk("busy", {63'b0, busy}, {63'b0, m_busy});
        chk("done", {63'b0, done}, {63'b0, m_done});
        chk("div_by_zero", {63'b0, dbz}, {63'b0, m_dbz});
        chk("hi", {32'b0, hi}, {32'b0, m_hi});
        chk("lo", {32'b0, lo}, {32'b0, m_lo});
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", {63'b0, busy}, 64'd0);
        chk("reset done", {63'b0, done}, 64'd0);
        chk("reset dbz", {63'b0, dbz}, 64'd0);
        chk("reset hi", {32'b0, hi}, 64'd0);
        chk("reset lo", {32'b0, lo}, 64'd0);
        rst_n = 1'b1;

        run("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run("mult_neg3x7", 2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run("divu_by0", 2'b10, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1);
        run("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        run("div_by0", 2'b11, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
        run("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run("div_7_m2", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
        run("div_m7_m2", 2'b11, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3, 1'b0);
        run("mult_min_sq", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
        run("multu_shift", 2'b00, 32'h1234_5678, 32'h10, 32'h1, 32'h2345_6780, 1'b0);
        run("divu_by1", 2'b10, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'hFFFF_FFFF, 1'b0);
        run("mult_m1_min", 2'b01, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 32'h8000_0000, 1'b0);

        // Stray start while busy must be ignored; the next op issues in the done cycle.
        issue(2'b00, 32'd6, 32'd7);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        op    = 2'b10;
        opa   = 32'd99;
        opb   = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("multu_6x7", 5, 32'h0, 32'd42, 1'b0);
        run("divu_1000_3", 2'b10, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0);

        // Reset mid-divide: outputs clear at once, no done, start ignored while in reset.
        issue(2'b10, 32'd1000, 32'd7);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort busy", {63'b0, busy}, 64'd0);
        chk("abort done", {63'b0, done}, 64'd0);
        chk("abort hi", {32'b0, hi}, 64'd0);
        chk("abort lo", {32'b0, lo}, 64'd0);
        start = 1'b1;
        op    = 2'b00;
        opa   = 32'd3;
        opb   = 32'd5;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ignores start", {63'b0, busy}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("accept after reset", {63'b0, busy}, 64'd1);
        wait_done("multu_3x5", 0, 32'h0, 32'd15, 1'b0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    join_any
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand width; hi/lo are WIDTH each; only 32 is supported for signoff.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a new operation; sampled on a rising edge only while busy=0.
REQ-005 op  input  2  00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed).
REQ-006 operand_a  input  32  multiplicand / dividend, driven from register-file ReadData1.
REQ-007 operand_b  input  32  multiplier / divisor, driven from register-file ReadData2.
REQ-008 busy  output  1  high while an operation is in flight.
REQ-009 done  output  1  one-cycle pulse: hi/lo hold the new result.
REQ-010 hi  output  32  product[63:32] or remainder.
REQ-011 lo  output  32  product[31:0] or quotient.
REQ-012 div_by_zero  output  1  pulses with done when a DIV/DIVU had operand_b=0.

Function
REQ-013 States: IDLE, CALC, FIN; state register and all outputs are flops.
REQ-014 IDLE: start=1 on edge k latches op, operand_a, operand_b, captures sign information, converts signed operands to magnitudes, and enters CALC; busy=1 from edge k.
REQ-015 CALC: exactly WIDTH iterations, one per cycle: shift-add for multiply, restoring shift-subtract for divide; iteration counter 0..WIDTH-1; after the last iteration, go to FIN.
REQ-016 FIN: one cycle; applies sign correction, writes hi/lo; on the exiting edge (k+WIDTH+1), state=IDLE, busy=0, done=1 for one cycle.
REQ-017 Latency: fixed at WIDTH+1 edges from the start edge to the done edge, for every op and operand value, including divide-by-zero.
REQ-018 start while busy=1: ignored, no queuing; operand/op changes while busy=1: ignored.
REQ-019 start=1 in the done cycle (busy=0): accepted; back-to-back issue gives one op per WIDTH+2 cycles.
REQ-020 hi/lo hold their value between done pulses; they change only on a done edge or on reset.
REQ-021 MULTU: {hi,lo} = unsigned 64-bit product. MULT: {hi,lo} = two's-complement 64-bit signed product.
REQ-022 DIVU: lo = floor(a/b), hi = a mod b, both unsigned.
REQ-023 DIV: quotient truncates toward zero; remainder takes the sign of the dividend; |hi| < |b|.
REQ-024 DIV with a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0x00000000; no flag.
REQ-025 Divide by zero (b=0, either divide op): lo=0xFFFFFFFF, hi=operand_a as latched; div_by_zero=1 with done.
REQ-026 div_by_zero is 0 whenever done=0, and is 0 for multiply ops.

Reset
REQ-027 rst_n=0: immediately (asynchronously) forces state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, and clears the iteration counter and latched operands.
REQ-028 Reset asserted mid-operation: aborts with no done pulse; after release, the unit accepts start on the first rising edge with rst_n=1.
REQ-029 start is ignored on any edge where rst_n=0.

Verification
REQ-030 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done 33 edges after start; hi=0xFFFFFFFE, lo=0x00000001.
REQ-031 MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21); DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-032 DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100, div_by_zero=1 for exactly one cycle, coincident with done.
REQ-033 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
REQ-034 Issue MULTU 6*7, then pulse start again 5 cycles later with DIVU -> second start ignored; hi=0, lo=42; a start in the done cycle is accepted and completes 33 edges later.
REQ-035 Assert rst_n=0 during iteration 10 of DIVU -> busy, done, hi, lo drop to 0 immediately; no done pulse; a fresh MULTU 3*5 after release gives lo=15.
